dw_win_gen: RTL and testbench

DW_WIN_GEN -- requirements
Module: dw_win_gen

---
 rtl/dw_win_gen.sv | 107 ++++++++++
 tb/tb_dw_win_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dw_win_gen.sv
// Depthwise sliding-window generator: per-channel KxK window from column stream.
// Ports: clk, rstn, data_in/valid_in/sol_in/ready_out in, win_out/valid_out/eol_out/ready_in out.
module dw_win_gen #(
    parameter int CH_NUM     = 18,
    parameter int DATA_WIDTH = 8,
    parameter int K          = 3,
    parameter int STRIDE     = 1,
    parameter int IMG_W      = 32
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [CH_NUM*K*DATA_WIDTH-1:0]      data_in,
    input  logic                                valid_in,
    input  logic                                sol_in,
    output logic                                ready_out,
    output logic [CH_NUM*K*K*DATA_WIDTH-1:0]    win_out,
    output logic                                valid_out,
    output logic                                eol_out,
    input  logic                                ready_in
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int WW = CH_NUM*K*K*DATA_WIDTH;
    localparam int RW = K*DATA_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(IMG_W-1);
    localparam logic [CW-1:0] KM1  = CW'(K-1);

    logic [WW-1:0] win_q, win_d, win_sh;
    logic [CW-1:0] col_q, col_d, idx;
    logic          ph_q, ph_d, ph_n;
    logic          valid_q, valid_d;
    logic          eol_q, eol_d;
    logic          acc, emit;

    assign ready_out = !valid_q || ready_in;
    assign acc       = valid_in && ready_out;

    // Index of the column being offered; sol forces a new line.
    always_comb begin
        idx = col_q + 1'b1;
        if (sol_in || col_q == LAST)
            idx = '0;
    end

    // Phase restarts at the first full window, then toggles for stride 2.
    always_comb begin
        ph_n = ph_q;
        if (idx == KM1)
            ph_n = 1'b0;
        else if (idx > KM1)
            ph_n = (STRIDE == 2) ? ~ph_q : 1'b0;
    end

    assign emit = (idx >= KM1) && !ph_n;

    // Each (ch,r) row is K contiguous pixels; c=0 is the lowest slot.
    always_comb begin
        win_sh = win_q;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            for (int r = 0; r < K; r++) begin
                win_sh[(ch*K+r)*RW + DATA_WIDTH +: (K-1)*DATA_WIDTH] =
                    win_q[(ch*K+r)*RW +: (K-1)*DATA_WIDTH];
                win_sh[(ch*K+r)*RW +: DATA_WIDTH] =
                    data_in[(ch*K+r)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        win_d   = win_q;
        col_d   = col_q;
        ph_d    = ph_q;
        valid_d = valid_q;
        eol_d   = eol_q;
        if (acc) begin
            win_d   = win_sh;
            col_d   = idx;
            ph_d    = ph_n;
            valid_d = emit;
            eol_d   = emit && (idx == LAST);
        end else if (ready_in) begin
            valid_d = 1'b0;
            eol_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_q   <= '0;
            col_q   <= LAST;
            ph_q    <= 1'b0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            win_q   <= win_d;
            col_q   <= col_d;
            ph_q    <= ph_d;
            valid_q <= valid_d;
            eol_q   <= eol_d;
        end
    end

    assign win_out   = win_q;
    assign valid_out = valid_q;
    assign eol_out   = eol_q;

endmodule

// File: tb/tb_dw_win_gen.sv
// Scoreboard bench for dw_win_gen: stride-1 and stride-2 instances.
// Directed column streams; expected windows queued at issue, checked by monitors.
module tb_dw_win_gen;

    localparam int CH = 2;
    localparam int DW = 8;
    localparam int K  = 3;
    localparam int IW = 8;
    localparam int DIW = CH*K*DW;
    localparam int WW  = CH*K*K*DW;

    typedef struct packed {
        logic [WW-1:0] win;
        logic          eol;
    } exp_t;

    logic           clk = 1'b0;
    logic           rstn;
    logic [DIW-1:0] data_in;
    logic           sol_in;
    logic           v1, v2;
    logic           ready_in;
    logic           ro1, ro2;
    logic [WW-1:0]  w1, w2;
    logic           vo1, vo2;
    logic           eo1, eo2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_wait;

    always #5 clk = ~clk;

    dw_win_gen #(.CH_NUM(CH), .DATA_WIDTH(DW), .K(K), .STRIDE(1), .IMG_W(IW)) u1 (
        .clk(clk), .rstn(rstn), .data_in(data_in), .valid_in(v1),
        .sol_in(sol_in), .ready_out(ro1), .win_out(w1), .valid_out(vo1),
        .eol_out(eo1), .ready_in(ready_in)
    );

    dw_win_gen #(.CH_NUM(CH), .DATA_WIDTH(DW), .K(K), .STRIDE(2), .IMG_W(IW)) u2 (
        .clk(clk), .rstn(rstn), .data_in(data_in), .valid_in(v2),
        .sol_in(sol_in), .ready_out(ro2), .win_out(w2), .valid_out(vo2),
        .eol_out(eo2), .ready_in(ready_in)
    );

    function automatic logic [DW-1:0] pix(int tag, int ch, int r);
        return DW'((tag << 3) | (ch << 2) | r);
    endfunction

    function automatic logic [DIW-1:0] mkcol(int tag);
        logic [DIW-1:0] c = '0;
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < K; r++)
                c[(ch*K+r)*DW +: DW] = pix(tag, ch, r);
        return c;
    endfunction

    function automatic logic [WW-1:0] mkwin(int t0, int t1, int t2);
        logic [WW-1:0] w = '0;
        int t;
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) begin
                    t = (c == 0) ? t0 : (c == 1) ? t1 : t2;
                    w[((ch*K+r)*K+c)*DW +: DW] = pix(t, ch, r);
                end
        return w;
    endfunction

    task automatic chk(string nm, logic [WW-1:0] act, logic [WW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic expw(int d, int t0, int t1, int t2, bit eol);
        exp_t e;
        e.win = mkwin(t0, t1, t2);
        e.eol = eol;
        if (d == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic send(int d, bit sol, int tag);
        int  w;
        bit  acc;
        w   = 0;
        acc = 1'b0;
        data_in = mkcol(tag);
        sol_in  = sol;
        if (d == 1) v1 = 1'b1;
        else v2 = 1'b1;
        while (!acc && w < 50) begin
            @(negedge clk);
            acc = (d == 1) ? ro1 : ro2;
            @(posedge clk);
            #1;
            if (!acc) w++;
        end
        last_wait = w;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout dut%0d tag %0d: waited %0d cycles", d, tag, w);
        end
    endtask

    task automatic idle();
        v1 = 1'b0;
        v2 = 1'b0;
        sol_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic mon(int d);
        exp_t e;
        logic vo, eo, ro;
        logic [WW-1:0] wv;
        int sz;
        forever begin
            @(negedge clk);
            vo = (d == 1) ? vo1 : vo2;
            eo = (d == 1) ? eo1 : eo2;
            ro = (d == 1) ? ro1 : ro2;
            wv = (d == 1) ? w1 : w2;
            sz = (d == 1) ? q1.size() : q2.size();
            if (!rstn) continue;
            if (vo && ready_in) begin
                if (sz == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_window dut%0d: got %h expected none", d, wv);
                end else begin
                    e = (d == 1) ? q1.pop_front() : q2.pop_front();
                    chk($sformatf("win dut%0d", d), wv, e.win);
                    chk($sformatf("eol dut%0d", d), WW'(eo), WW'(e.eol));
                end
            end else if (vo) begin
                if (sz != 0) begin
                    e = (d == 1) ? q1[0] : q2[0];
                    chk($sformatf("stall_win dut%0d", d), wv, e.win);
                end
                chk($sformatf("stall_ready dut%0d", d), WW'(ro), WW'(0));
            end else begin
                chk($sformatf("idle_eol dut%0d", d), WW'(eo), WW'(0));
            end
        end
    endtask

    initial begin
        rstn     = 1'b0;
        data_in  = '0;
        sol_in   = 1'b0;
        v1       = 1'b0;
        v2       = 1'b0;
        ready_in = 1'b1;
        fork
            mon(1);
            mon(2);
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("rst_win", w1, '0);
        chk("rst_valid", WW'(vo1), WW'(0));
        chk("rst_eol", WW'(eo1), WW'(0));
        chk("rst_ready", WW'(ro1), WW'(1));
        chk("rst_valid2", WW'(vo2), WW'(0));
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Gapless stride-1 line
        send(1, 1, 1);
        send(1, 0, 2);
        expw(1, 3, 2, 1, 0); send(1, 0, 3);
        expw(1, 4, 3, 2, 0); send(1, 0, 4);
        expw(1, 5, 4, 3, 0); send(1, 0, 5);
        expw(1, 6, 5, 4, 0); send(1, 0, 6);
        expw(1, 7, 6, 5, 0); send(1, 0, 7);
        expw(1, 8, 7, 6, 1); send(1, 0, 8);
        idle();
        idle();

        // Backpressure: hold ready_in low with a column pending
        send(1, 1, 1);
        send(1, 0, 2);
        expw(1, 3, 2, 1, 0); send(1, 0, 3);
        ready_in = 1'b0;
        data_in  = mkcol(4);
        sol_in   = 1'b0;
        v1       = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        expw(1, 4, 3, 2, 0); send(1, 0, 4);
        chk("release_same_cycle", WW'(last_wait), WW'(0));
        expw(1, 5, 4, 3, 0); send(1, 0, 5);
        expw(1, 6, 5, 4, 0); send(1, 0, 6);
        expw(1, 7, 6, 5, 0); send(1, 0, 7);
        expw(1, 8, 7, 6, 1); send(1, 0, 8);
        idle();

        // Mid-line restart
        send(1, 1, 1);
        send(1, 0, 2);
        expw(1, 3, 2, 1, 0); send(1, 0, 3);
        expw(1, 4, 3, 2, 0); send(1, 0, 4);
        send(1, 1, 9);
        send(1, 0, 10);
        expw(1, 11, 10, 9, 0); send(1, 0, 11);
        expw(1, 12, 11, 10, 0); send(1, 0, 12);
        expw(1, 13, 12, 11, 0); send(1, 0, 13);
        expw(1, 14, 13, 12, 0); send(1, 0, 14);
        expw(1, 15, 14, 13, 0); send(1, 0, 15);
        expw(1, 16, 15, 14, 1); send(1, 0, 16);
        idle();

        // Reset mid-line, asynchronous clear
        send(1, 1, 1);
        send(1, 0, 2);
        expw(1, 3, 2, 1, 0); send(1, 0, 3);
        expw(1, 4, 3, 2, 0); send(1, 0, 4);
        idle();
        rstn = 1'b0;
        #1;
        chk("async_rst_win", w1, '0);
        chk("async_rst_valid", WW'(vo1), WW'(0));
        chk("async_rst_eol", WW'(eo1), WW'(0));
        chk("async_rst_ready", WW'(ro1), WW'(1));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send(1, 0, 20);
        send(1, 0, 21);
        expw(1, 22, 21, 20, 0); send(1, 0, 22);
        expw(1, 23, 22, 21, 0); send(1, 0, 23);
        expw(1, 24, 23, 22, 0); send(1, 0, 24);
        expw(1, 25, 24, 23, 0); send(1, 0, 25);
        expw(1, 26, 25, 24, 0); send(1, 0, 26);
        expw(1, 27, 26, 25, 1); send(1, 0, 27);
        idle();

        // valid_in gaps
        send(1, 1, 1); idle();
        send(1, 0, 2); idle();
        expw(1, 3, 2, 1, 0); send(1, 0, 3); idle();
        expw(1, 4, 3, 2, 0); send(1, 0, 4); idle();
        expw(1, 5, 4, 3, 0); send(1, 0, 5); idle();
        expw(1, 6, 5, 4, 0); send(1, 0, 6); idle();
        expw(1, 7, 6, 5, 0); send(1, 0, 7); idle();
        expw(1, 8, 7, 6, 1); send(1, 0, 8); idle();

        // Stride 2 line
        send(2, 1, 1);
        send(2, 0, 2);
        expw(2, 3, 2, 1, 0); send(2, 0, 3);
        send(2, 0, 4);
        expw(2, 5, 4, 3, 0); send(2, 0, 5);
        send(2, 0, 6);
        expw(2, 7, 6, 5, 0); send(2, 0, 7);
        send(2, 0, 8);
        idle();

        repeat (5) @(posedge clk);
        #1;
        chk("q1_drained", WW'(q1.size()), WW'(0));
        chk("q2_drained", WW'(q2.size()), WW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
